// File: rtl/noc_pkg.sv
// noc_pkg: shared mesh-router constants.
// Output port indices (L, N, E, W, S) and the default port count and
// downstream FIFO depth used by the credit flow-control slice.
package noc_pkg;
  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_S = 4;
  localparam int NUM_PORTS_DEF = 5;
  localparam int FIFO_DEPTH_DEF = 4;
endpackage

// File: rtl/credit_flowcontrol_if.sv
// credit_flowcontrol_if: request/credit bundle between routing, flow control and arbiter.
// Signals: port_req, flit_sent and credit_in (from the router side),
// ready_out, credit_cnt (packed, CNT_W bits per port) and err (from flow control).
// Modports: master = router side, slave = credit_flowcontrol.
interface credit_flowcontrol_if
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W = $clog2(FIFO_DEPTH + 1)
);
  logic [NUM_PORTS-1:0] port_req;
  logic [NUM_PORTS-1:0] flit_sent;
  logic [NUM_PORTS-1:0] credit_in;
  logic [NUM_PORTS-1:0] ready_out;
  logic [NUM_PORTS*CNT_W-1:0] credit_cnt;
  logic [NUM_PORTS-1:0] err;
  modport master(output port_req, flit_sent, credit_in, input ready_out, credit_cnt, err);
  modport slave(input port_req, flit_sent, credit_in, output ready_out, credit_cnt, err);
endinterface

// File: rtl/credit_counter.sv
// credit_counter: saturating credit counter for one output port.
// Ports: clk, rst (sync, active-high), dec (flit sent), inc (credit returned),
// cnt (current credits), nonzero (cnt != 0), err (sticky under/overflow).
// Macro CREDIT_BYPASS_EN: a send at zero credits paired with a same-cycle
// credit return is legal and raises no error.
module credit_counter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             err
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(FIFO_DEPTH);
  logic empty, full, under, over;
  assign empty = cnt == '0;
  assign full = cnt == MAX_CNT;
  assign nonzero = !empty;
`ifdef CREDIT_BYPASS_EN
  assign under = dec && !inc && empty;
`else
  // Without bypass the returned credit is not visible yet, so the send was illegal.
  assign under = dec && empty;
`endif
  assign over = inc && !dec && full;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= MAX_CNT;
      err <= 1'b0;
    end else begin
      cnt <= (inc && !dec && !full) ? cnt + CNT_W'(1) :
             (dec && !inc && !empty) ? cnt - CNT_W'(1) : cnt;
      err <= err | under | over;
    end
  end
endmodule

// File: rtl/credit_flowcontrol.sv
// credit_flowcontrol: per-output-port credit flow control for the mesh router.
// Ports: clk, rst (sync, active-high), bus (credit_flowcontrol_if.slave):
// port_req/flit_sent/credit_in in, ready_out/credit_cnt/err out.
// Macro CREDIT_BYPASS_EN: a credit arriving at zero count grants ready the same cycle.
module credit_flowcontrol
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  credit_flowcontrol_if.slave bus
);
  logic [NUM_PORTS-1:0] nonzero;
  logic [NUM_PORTS-1:0] err;
  logic [NUM_PORTS-1:0] avail;
  logic [CNT_W-1:0] cnt [NUM_PORTS];
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    credit_counter #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .dec(bus.flit_sent[i]),
      .inc(bus.credit_in[i]),
      .cnt(cnt[i]),
      .nonzero(nonzero[i]),
      .err(err[i])
    );
    assign bus.credit_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`ifdef CREDIT_BYPASS_EN
  assign avail = nonzero | bus.credit_in;
`else
  assign avail = nonzero;
`endif
  assign bus.ready_out = rst ? '0 : bus.port_req & avail;
  assign bus.err = err;
endmodule

// File: tb/tb_credit_flowcontrol.sv
// tb_credit_flowcontrol: scoreboard bench for credit_flowcontrol.
module tb_credit_flowcontrol;
  import noc_pkg::*;
  localparam int N = 5;
  localparam int D = 4;
  localparam int W = $clog2(D + 1);
`ifdef CREDIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [N*W-1:0] cnt;
    logic [N-1:0] err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int m_cnt [N];
  logic [N-1:0] m_err = '0;
  exp_t sb [$];
  always #5 clk = ~clk;
  credit_flowcontrol_if #(.NUM_PORTS(N), .FIFO_DEPTH(D)) bus ();
  credit_flowcontrol #(.NUM_PORTS(N), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] sent,
                       input logic [N-1:0] crd, input logic r);
    logic [N-1:0] er;
    exp_t e;
    bus.port_req = req;
    bus.flit_sent = sent;
    bus.credit_in = crd;
    rst = r;
    #1;
    for (int i = 0; i < N; i++)
      er[i] = !r && req[i] && (m_cnt[i] != 0 || (BYP && crd[i]));
    check("ready", 32'(bus.ready_out), 32'(er));
    for (int i = 0; i < N; i++) begin
      if (r) begin
        m_cnt[i] = D;
        m_err[i] = 1'b0;
      end else if (sent[i] && !crd[i]) begin
        if (m_cnt[i] == 0) m_err[i] = 1'b1;
        else m_cnt[i]--;
      end else if (crd[i] && !sent[i]) begin
        if (m_cnt[i] == D) m_err[i] = 1'b1;
        else m_cnt[i]++;
      end else if (crd[i] && sent[i] && m_cnt[i] == 0 && !BYP) begin
        m_err[i] = 1'b1;
      end
      e.cnt[i*W +: W] = W'(m_cnt[i]);
    end
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #2;
    e = sb.pop_front();
    check("credit_cnt", 32'(bus.credit_cnt), 32'(e.cnt));
    check("err", 32'(bus.err), 32'(e.err));
  endtask
  initial begin
    logic [N-1:0] pe, pn, pw, ps, pl;
    pe = N'(1) << PORT_E;
    pn = N'(1) << PORT_N;
    pw = N'(1) << PORT_W;
    ps = N'(1) << PORT_S;
    pl = N'(1) << PORT_L;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    repeat (2) cycle('1, '0, '0, 1'b1);
    cycle('1, '0, '0, 1'b0);
    repeat (4) cycle(pe, pe, '0, 1'b0);
    cycle(pe, '0, '0, 1'b0);
    cycle(pe, '0, pe, 1'b0);
    cycle(pe, '0, '0, 1'b0);
    repeat (2) cycle(pn, pn, '0, 1'b0);
    cycle(pn, pn, pn, 1'b0);
    repeat (4) cycle(pw, pw, '0, 1'b0);
    cycle(pw, pw, '0, 1'b0);
    cycle(pw, pw, pw, 1'b0);
    repeat (2) cycle('1, '0, '0, 1'b0);
    cycle(ps, '0, ps, 1'b0);
    cycle(ps, '0, '0, 1'b0);
    repeat (4) cycle(pl, pl, '0, 1'b0);
    cycle(pl, pl, pl, 1'b0);
    cycle(pl, '0, '0, 1'b0);
    cycle('1, '0, '0, 1'b1);
    cycle('1, '0, '0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      logic [N-1:0] req, crd, sent;
      req = N'($urandom);
      crd = N'($urandom) & N'($urandom);
      sent = req & bus.ready_out;
      if (k % 37 == 0) sent = N'($urandom);
      cycle(req, sent, crd, k % 101 == 100);
    end
    cycle('1, '0, '0, 1'b1);
    cycle('1, '0, '0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
